// File: rtl/bus_mem_slave.sv
// bus_mem_slave: parametrised memory-mapped scratch RAM slave.
// A request is accepted in IDLE when ce=1. The slave then spends WAIT_CYC
// wait states, and returns a one-cycle ready strobe with err.
// Optional byte enables are compiled in when BUS_MEM_BYTE_EN_EN is defined.
module bus_mem_slave #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_wr,
`ifdef BUS_MEM_BYTE_EN_EN
  input  logic [DATA_W/8-1:0] be,
`endif
  output logic [DATA_W-1:0] data_rd,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LD = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
  // One extra bit so that DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  // Parameter sanity checks, evaluated at elaboration.
  if (DEPTH < 1 || DEPTH > 2**ADDR_W) begin : g_depth_check
    $error("bus_mem_slave: DEPTH must be in 1..2**ADDR_W");
  end
  if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_wait_check
    $error("bus_mem_slave: WAIT_CYC must be in 0..15");
  end

`ifdef BUS_MEM_BYTE_EN_EN
  localparam int NB = DATA_W / 8;
  if (DATA_W % 8 != 0) begin : g_be_width_check
    $error("bus_mem_slave: DATA_W must be a multiple of 8 with byte enables");
  end
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  // Captured request fields
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              wr_q;
  logic              rd_q;

  // Request currently being serviced: live inputs on the accepting edge, captured copy afterwards
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_wr;
  logic              req_rd;
  logic              req_err;
  logic              enter_resp;
  logic              do_write;
  logic [IDX_W-1:0]  idx;

`ifdef BUS_MEM_BYTE_EN_EN
  logic [NB-1:0] be_q;
  logic [NB-1:0] req_be;
`endif

  // Select the request view and decode the response conditions
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    req_addr = addr_q;
    req_data = data_q;
    req_wr   = wr_q;
    req_rd   = rd_q;
`ifdef BUS_MEM_BYTE_EN_EN
    req_be   = be_q;
`endif
    if (state == IDLE) begin
      req_addr = addr;
      req_data = data_wr;
      req_wr   = wr;
      req_rd   = rd;
`ifdef BUS_MEM_BYTE_EN_EN
      req_be   = be;
`endif
    end
    // Both strobes or neither strobe is illegal, as is an address past the array.
    req_err    = (req_wr == req_rd) || ({1'b0, req_addr} >= DEPTH_X);
    enter_resp = ((state == IDLE) && ce && (WAIT_CYC == 0)) ||
                 ((state == WAIT) && (cnt == 4'd0));
    do_write   = enter_resp && req_wr && !req_err && rst_n;
    idx        = req_addr[IDX_W-1:0];
  end

  // Capture request fields on acceptance
  // NOTE: pure datapath registers carry no reset; they are only read after being loaded.
  always_ff @(posedge clk) begin
    if (state == IDLE && ce) begin
      addr_q <= addr;
      data_q <= data_wr;
      wr_q   <= wr;
      rd_q   <= rd;
`ifdef BUS_MEM_BYTE_EN_EN
      be_q   <= be;
`endif
    end
  end

  // Control FSM with registered response outputs
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ready   <= 1'b0;
      err     <= 1'b0;
      data_rd <= '0;
    end else begin
      ready <= enter_resp;
      err   <= enter_resp && req_err;
      if (enter_resp) begin
        if (req_err)
          data_rd <= '0;
        else if (req_rd)
          data_rd <= mem[idx];
      end
      case (state)
        IDLE: begin
          if (ce) begin
            state <= (WAIT_CYC > 0) ? WAIT : RESP;
            cnt   <= WAIT_LD;
          end
        end
        WAIT: begin
          if (cnt == 4'd0)
            state <= RESP;
          else
            cnt <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory write port; commits on the edge that enters RESP
  // NOTE: the array is deliberately not reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (do_write) begin
`ifdef BUS_MEM_BYTE_EN_EN
      for (int i = 0; i < NB; i++) begin
        if (req_be[i])
          mem[idx][8*i +: 8] <= req_data[8*i +: 8];
      end
`else
      mem[idx] <= req_data;
`endif
    end
  end

  assign busy = (state != IDLE);

endmodule
